// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined single-precision compare / min-max unit.
// Stage 1 captures the operands and their flush-to-zero total-order keys,
// stage 2 compares the keys and forms the result. Valid/ready on both sides,
// one op per cycle when the consumer keeps up.
module fcmp_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_FEQ  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FLE  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } op_e;

  // Total-order key: zeros and denormals collapse to one point, positives sit
  // above it in magnitude order, negatives below it in reversed magnitude order.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[30:23] == 8'h00)
      return 32'h8000_0000;
    else if (!x[31])
      return {1'b1, x[30:23], x[22:0]};
    else
      return {1'b0, ~x[30:23], ~x[22:0]};
  endfunction

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_x1, s1_x2;
  logic [31:0]      s1_k1, s1_k2;

  logic             s2_valid;
  logic [31:0]      s2_y;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_load;
  logic             s1_load;
  logic             lt, eq;
  logic [31:0]      res;

  // Advance rules: a stage loads when it is empty or its successor loads.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  assign out_valid = s2_valid;
  assign y         = s2_y;
  assign out_tag   = s2_tag;

  // Stage-2 result selection from the registered keys.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res = 32'h0;
    lt  = (s1_k1 < s1_k2);
    eq  = (s1_k1 == s1_k2);
    case (s1_op)
      OP_FEQ:  res = {31'b0, eq};
      OP_FLT:  res = {31'b0, lt};
      OP_FLE:  res = {31'b0, lt | eq};
      OP_FMIN: res = (lt || eq) ? s1_x1 : s1_x2;
      OP_FMAX: res = lt ? s1_x2 : s1_x1;
      default: res = 32'h0;
    endcase
  end

  // Stage 1: capture operands, op, tag and keys on an accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      s1_valid <= 1'b0;
      s1_op    <= 3'd0;
      s1_tag   <= '0;
      s1_x1    <= 32'h0;
      s1_x2    <= 32'h0;
      s1_k1    <= 32'h0;
      s1_k2    <= 32'h0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op;
        s1_tag <= in_tag;
        s1_x1  <= x1;
        s1_x2  <= x2;
        s1_k1  <= order_key(x1);
        s1_k2  <= order_key(x2);
      end
    end
  end

  // Stage 2: register the result; y/out_tag hold while stalled or on a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= 32'h0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y   <= res;
        s2_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed bench for fcmp_pipe with an expected-result queue.
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2;
  logic [2:0]  op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [3:0]  out_tag;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] y;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_y;
  logic [3:0]  prev_tag;

  fcmp_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'h1);
        check("stall_y", y, prev_y);
        check("stall_tag", {28'b0, out_tag}, {28'b0, prev_tag});
      end
      if (out_valid && out_ready) begin
        check("unexpected_out", {31'b0, sb.size() != 0}, 32'h1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("result_y", y, e.y);
          check("result_tag", {28'b0, out_tag}, {28'b0, e.tag});
          pop_cyc.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_tag   = out_tag;
    end
  end

  // Present an op (called at posedge+1); returns at posedge+1 after its acceptance edge.
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic [31:0] exp_y);
    int waited;
    in_valid = 1'b1;
    op = o; x1 = a; x2 = b; in_tag = t;
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!in_ready) begin
      total++; bad++;
      $error("FAIL send_timeout tag=%0d observed=in_ready_low expected=accept", t);
    end else begin
      sb.push_back('{tag: t, y: exp_y});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int waited;
    in_valid = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", sb.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with an op presented: nothing may be accepted.
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd1; x1 = 32'h3F80_0000; x2 = 32'h4000_0000; in_tag = 4'd7;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_y", y, 32'h0);
      check("rst_tag", {28'b0, out_tag}, 32'h0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1 check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_out", {31'b0, out_valid}, 32'h0);
    end
    @(posedge clk); #1;

    // Latency: not valid one edge after acceptance, valid after the second.
    send(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd1, 32'h1);
    check("lat_early", {31'b0, out_valid}, 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_valid", {31'b0, out_valid}, 32'h1);
    check("lat_y", y, 32'h1);
    @(posedge clk); #1;

    // Directed compare / min-max cases, issued back to back.
    send(3'd1, 32'h4000_0000, 32'h3F80_0000, 4'd2, 32'h0);
    send(3'd2, 32'h3F80_0000, 32'h3F80_0000, 4'd3, 32'h1);
    send(3'd0, 32'h0000_0000, 32'h8000_0000, 4'd4, 32'h1);
    send(3'd0, 32'h0000_0001, 32'h8040_0000, 4'd5, 32'h1);
    send(3'd1, 32'hC000_0000, 32'hBF80_0000, 4'd6, 32'h1);
    send(3'd3, 32'hBF80_0000, 32'h3F00_0000, 4'd7, 32'hBF80_0000);
    send(3'd4, 32'hBF80_0000, 32'h3F00_0000, 4'd8, 32'h3F00_0000);
    send(3'd3, 32'h0000_0001, 32'h0000_0000, 4'd9, 32'h0000_0001);
    send(3'd6, 32'h3F80_0000, 32'h4000_0000, 4'd10, 32'h0);
    send(3'd2, 32'hFF80_0000, 32'h7F80_0000, 4'd11, 32'h1);
    drain();

    // Backpressure: stream tags 1..5 while the consumer stalls for a few cycles.
    pop_cyc.delete();
    out_ready = 1'b0;
    fork
      begin
        send(3'd4, 32'h3F80_0001, 32'h3F80_0000, 4'd1, 32'h3F80_0001);
        send(3'd4, 32'h3F80_0002, 32'h3F80_0000, 4'd2, 32'h3F80_0002);
        #1 check("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        check("bp_head_tag", {28'b0, out_tag}, 32'h1);
        send(3'd4, 32'h3F80_0003, 32'h3F80_0000, 4'd3, 32'h3F80_0003);
        send(3'd4, 32'h3F80_0004, 32'h3F80_0000, 4'd4, 32'h3F80_0004);
        send(3'd4, 32'h3F80_0005, 32'h3F80_0000, 4'd5, 32'h3F80_0005);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", pop_cyc.size(), 32'd5);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("bp_no_gap", pop_cyc[i] - pop_cyc[i-1], 32'd1);

    // Asynchronous reset with two ops held in the pipe.
    out_ready = 1'b0;
    send(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd12, 32'h1);
    send(3'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd13, 32'h1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("async_rst_no_stale", {31'b0, out_valid}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
